// File: rtl/gpio_arb_pkg.sv
// rtl/gpio_arb_pkg.sv - shared types and constants for the gpio Wishbone arbiter
//
// Purpose : arbiter state encoding, idle grant value and timeout counter width.
// Ports   : none (package).
package gpio_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } arb_state_t;

   localparam logic [1:0]  GNT_IDLE = 2'b00;
   localparam int unsigned TO_CNT_W = 8;

endpackage

// File: rtl/gpio_arb_timeout.sv
// rtl/gpio_arb_timeout.sv - stalled-grant watchdog for the gpio Wishbone arbiter
//
// Purpose : counts cycles a granted master strobes without a slave response and
//           flags expiry once the count reaches TIMEOUT_CYCLES.
// Ports   : wb_clk, wb_rst_n - clock, asynchronous active-low reset
//           active           - a grant is currently held
//           clear            - restart count (grant entry/change or any response)
//           stb              - strobe of the granted master
//           expire           - count has reached TIMEOUT_CYCLES under a grant
module gpio_arb_timeout
   import gpio_arb_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic wb_clk,
   input  logic wb_rst_n,
   input  logic active,
   input  logic clear,
   input  logic stb,
   output logic expire
);

   localparam logic [TO_CNT_W-1:0] LIMIT = TO_CNT_W'(TIMEOUT_CYCLES);

   logic [TO_CNT_W-1:0] cnt;

   always_ff @(posedge wb_clk or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         cnt <= '0;
      end else if (clear || !active) begin
         cnt <= '0;
      end else if (stb && (cnt != LIMIT)) begin
         cnt <= cnt + 1'b1;
      end
   end

   // Register-only decode keeps the slave response out of the abort path.
   assign expire = active && (cnt == LIMIT);

endmodule

// File: rtl/gpio_wb_arbiter.sv
// rtl/gpio_wb_arbiter.sv - two-master round-robin Wishbone B3 classic arbiter for the gpio slave
//
// Purpose : shares one gpio slave between m0 (CPU) and m1 (debug/DMA). The grant
//           is locked for the whole cyc of the winner; slave side is a
//           combinational mux of the granted master; responses go only to it.
// Ports   : wb_clk, wb_rst_n           - clock, asynchronous active-low reset
//           m0_*_i / m1_*_i            - master requests (adr, dat, we, cyc, stb, cti, bte)
//           m0_*_o / m1_*_o            - dat (unqualified), ack/err/rty (granted only)
//           s_*_o / s_*_i              - slave request mux and slave responses
//           gnt_o                      - {GNT1, GNT0}, 00 when idle
// Config  : define GPIO_ARB_TIMEOUT_EN to abort a grant after TIMEOUT_CYCLES
//           strobed cycles without a response (err pulse to the owner).
module gpio_wb_arbiter
   import gpio_arb_pkg::*;
#(
   parameter int wb_adr_width   = 3,
   parameter int wb_dat_width   = 8,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                    wb_clk,
   input  logic                    wb_rst_n,
   input  logic [wb_adr_width-1:0] m0_adr_i,
   input  logic [wb_dat_width-1:0] m0_dat_i,
   input  logic                    m0_we_i,
   input  logic                    m0_cyc_i,
   input  logic                    m0_stb_i,
   input  logic [2:0]              m0_cti_i,
   input  logic [1:0]              m0_bte_i,
   output logic [wb_dat_width-1:0] m0_dat_o,
   output logic                    m0_ack_o,
   output logic                    m0_err_o,
   output logic                    m0_rty_o,
   input  logic [wb_adr_width-1:0] m1_adr_i,
   input  logic [wb_dat_width-1:0] m1_dat_i,
   input  logic                    m1_we_i,
   input  logic                    m1_cyc_i,
   input  logic                    m1_stb_i,
   input  logic [2:0]              m1_cti_i,
   input  logic [1:0]              m1_bte_i,
   output logic [wb_dat_width-1:0] m1_dat_o,
   output logic                    m1_ack_o,
   output logic                    m1_err_o,
   output logic                    m1_rty_o,
   output logic [wb_adr_width-1:0] s_adr_o,
   output logic [wb_dat_width-1:0] s_dat_o,
   output logic                    s_we_o,
   output logic                    s_cyc_o,
   output logic                    s_stb_o,
   output logic [2:0]              s_cti_o,
   output logic [1:0]              s_bte_o,
   input  logic [wb_dat_width-1:0] s_dat_i,
   input  logic                    s_ack_i,
   input  logic                    s_err_i,
   input  logic                    s_rty_i,
   output logic [1:0]              gnt_o
);

   arb_state_t state, next_state;
   logic       last, next_last;   // master that held the most recent grant
   logic       expire;

   always_ff @(posedge wb_clk or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         state <= IDLE;
         last  <= 1'b1;
      end else begin
         state <= next_state;
         last  <= next_last;
      end
   end

   always_comb begin
      next_state = state;
      next_last  = last;
      case (state)
         IDLE: begin
            if (m0_cyc_i && m1_cyc_i) next_state = last ? GNT0 : GNT1;
            else if (m0_cyc_i)        next_state = GNT0;
            else if (m1_cyc_i)        next_state = GNT1;
         end
         GNT0: begin
            if (expire) begin
               next_state = IDLE;
               next_last  = 1'b0;
            end else if (!m0_cyc_i) begin
               next_state = m1_cyc_i ? GNT1 : IDLE;
               next_last  = 1'b0;
            end
         end
         GNT1: begin
            if (expire) begin
               next_state = IDLE;
               next_last  = 1'b1;
            end else if (!m1_cyc_i) begin
               next_state = m0_cyc_i ? GNT0 : IDLE;
               next_last  = 1'b1;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      s_adr_o  = m0_adr_i;
      s_dat_o  = m0_dat_i;
      s_cti_o  = m0_cti_i;
      s_bte_o  = m0_bte_i;
      s_we_o   = 1'b0;
      s_cyc_o  = 1'b0;
      s_stb_o  = 1'b0;
      m0_ack_o = 1'b0;
      m0_err_o = 1'b0;
      m0_rty_o = 1'b0;
      m1_ack_o = 1'b0;
      m1_err_o = 1'b0;
      m1_rty_o = 1'b0;
      gnt_o    = GNT_IDLE;
      case (state)
         GNT0: begin
            s_we_o   = m0_we_i;
            s_cyc_o  = m0_cyc_i & ~expire;
            s_stb_o  = m0_stb_i & ~expire;
            m0_ack_o = s_ack_i;
            m0_err_o = s_err_i | expire;
            m0_rty_o = s_rty_i;
            gnt_o    = 2'b01;
         end
         GNT1: begin
            s_adr_o  = m1_adr_i;
            s_dat_o  = m1_dat_i;
            s_cti_o  = m1_cti_i;
            s_bte_o  = m1_bte_i;
            s_we_o   = m1_we_i;
            s_cyc_o  = m1_cyc_i & ~expire;
            s_stb_o  = m1_stb_i & ~expire;
            m1_ack_o = s_ack_i;
            m1_err_o = s_err_i | expire;
            m1_rty_o = s_rty_i;
            gnt_o    = 2'b10;
         end
         default: ;
      endcase
   end

   assign m0_dat_o = s_dat_i;
   assign m1_dat_o = s_dat_i;

`ifdef GPIO_ARB_TIMEOUT_EN
   logic to_active;
   logic to_clear;
   logic to_stb;

   assign to_active = (state != IDLE);
   // A grant change (handoff or exit) restarts the count, as does any response.
   assign to_clear  = s_ack_i | s_err_i | s_rty_i | (next_state != state);
   assign to_stb    = (state == GNT0) ? m0_stb_i :
                      (state == GNT1) ? m1_stb_i : 1'b0;

   gpio_arb_timeout #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .wb_clk  (wb_clk),
      .wb_rst_n(wb_rst_n),
      .active  (to_active),
      .clear   (to_clear),
      .stb     (to_stb),
      .expire  (expire)
   );
`else
   logic [TO_CNT_W-1:0] unused_timeout_cfg;

   assign unused_timeout_cfg = TO_CNT_W'(TIMEOUT_CYCLES);
   assign expire             = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_wb_arbiter.sv
// tb/tb_gpio_wb_arbiter.sv - directed self-checking bench for gpio_wb_arbiter
module tb_gpio_wb_arbiter;

   logic       wb_clk = 1'b0;
   logic       wb_rst_n;
   logic [2:0] m0_adr_i, m1_adr_i, s_adr_o;
   logic [7:0] m0_dat_i, m1_dat_i, m0_dat_o, m1_dat_o, s_dat_o, s_dat_i;
   logic       m0_we_i, m0_cyc_i, m0_stb_i, m1_we_i, m1_cyc_i, m1_stb_i;
   logic [2:0] m0_cti_i, m1_cti_i, s_cti_o;
   logic [1:0] m0_bte_i, m1_bte_i, s_bte_o, gnt_o;
   logic       m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o, m1_err_o, m1_rty_o;
   logic       s_we_o, s_cyc_o, s_stb_o, s_ack_i, s_err_i, s_rty_i;

   int checks = 0;
   int fails  = 0;

   gpio_wb_arbiter #(
      .wb_adr_width(3), .wb_dat_width(8), .TIMEOUT_CYCLES(16)
   ) dut (
      .wb_clk(wb_clk), .wb_rst_n(wb_rst_n),
      .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_we_i(m0_we_i), .m0_cyc_i(m0_cyc_i),
      .m0_stb_i(m0_stb_i), .m0_cti_i(m0_cti_i), .m0_bte_i(m0_bte_i), .m0_dat_o(m0_dat_o),
      .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_rty_o(m0_rty_o),
      .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_we_i(m1_we_i), .m1_cyc_i(m1_cyc_i),
      .m1_stb_i(m1_stb_i), .m1_cti_i(m1_cti_i), .m1_bte_i(m1_bte_i), .m1_dat_o(m1_dat_o),
      .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_rty_o(m1_rty_o),
      .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_we_o(s_we_o), .s_cyc_o(s_cyc_o),
      .s_stb_o(s_stb_o), .s_cti_o(s_cti_o), .s_bte_o(s_bte_o),
      .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
      .gnt_o(gnt_o)
   );

   always #5 wb_clk = ~wb_clk;

   task automatic tick();
      @(posedge wb_clk);
      #1;
   endtask

   task automatic idle_inputs();
      m0_adr_i = 3'd0; m0_dat_i = 8'h00; m0_we_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
      m0_cti_i = 3'd0; m0_bte_i = 2'd0;
      m1_adr_i = 3'd0; m1_dat_i = 8'h00; m1_we_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
      m1_cti_i = 3'd0; m1_bte_i = 2'd0;
      s_dat_i = 8'h00; s_ack_i = 1'b0; s_err_i = 1'b0; s_rty_i = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      wb_rst_n = 1'b0;
      tick();
      tick();
      wb_rst_n = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      idle_inputs();
      wb_rst_n = 1'b0;
      tick();
      checks++; if (gnt_o !== 2'b00) begin fails++; $display("FAIL reset_gnt: gnt_o=%b expected 00", gnt_o); end
      checks++; if (s_cyc_o !== 1'b0 || s_stb_o !== 1'b0) begin fails++; $display("FAIL reset_slave: cyc=%b stb=%b expected 0 0", s_cyc_o, s_stb_o); end
      wb_rst_n = 1'b1;
      tick();
   endtask

   task automatic test_m0_write();
      do_reset();
      m0_adr_i = 3'd0; m0_dat_i = 8'hA5; m0_we_i = 1'b1; m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
      #1;
      checks++; if (gnt_o !== 2'b00 || s_stb_o !== 1'b0) begin fails++; $display("FAIL wr_latency: gnt=%b stb=%b expected 00 0", gnt_o, s_stb_o); end
      tick();
      checks++; if (gnt_o !== 2'b01) begin fails++; $display("FAIL wr_gnt: gnt_o=%b expected 01", gnt_o); end
      checks++; if (s_stb_o !== 1'b1 || s_cyc_o !== 1'b1 || s_we_o !== 1'b1 || s_dat_o !== 8'hA5 || s_adr_o !== 3'd0)
         begin fails++; $display("FAIL wr_slave: stb=%b cyc=%b we=%b dat=%h adr=%0d expected 1 1 1 a5 0", s_stb_o, s_cyc_o, s_we_o, s_dat_o, s_adr_o); end
      checks++; if (m0_ack_o !== 1'b0) begin fails++; $display("FAIL wr_noack: m0_ack=%b expected 0", m0_ack_o); end
      s_ack_i = 1'b1;
      #1;
      checks++; if (m0_ack_o !== 1'b1 || m1_ack_o !== 1'b0) begin fails++; $display("FAIL wr_ack: m0_ack=%b m1_ack=%b expected 1 0", m0_ack_o, m1_ack_o); end
      tick();
      m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m0_we_i = 1'b0; s_ack_i = 1'b0;
      tick();
      checks++; if (gnt_o !== 2'b00 || m1_ack_o !== 1'b0) begin fails++; $display("FAIL wr_release: gnt=%b m1_ack=%b expected 00 0", gnt_o, m1_ack_o); end
   endtask

   task automatic test_tie();
      do_reset();
      m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 3'd2;
      m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_adr_i = 3'd5;
      tick();
      checks++; if (gnt_o !== 2'b01 || s_adr_o !== 3'd2) begin fails++; $display("FAIL tie_first: gnt=%b adr=%0d expected 01 2", gnt_o, s_adr_o); end
      m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
      tick();
      checks++; if (gnt_o !== 2'b10 || s_adr_o !== 3'd5) begin fails++; $display("FAIL tie_handoff: gnt=%b adr=%0d expected 10 5", gnt_o, s_adr_o); end
      m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
      tick();
      checks++; if (gnt_o !== 2'b00) begin fails++; $display("FAIL tie_idle: gnt_o=%b expected 00", gnt_o); end
      m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
      tick();
      checks++; if (gnt_o !== 2'b01) begin fails++; $display("FAIL tie_alternate: gnt_o=%b expected 01", gnt_o); end
      idle_inputs();
      tick();
      tick();
   endtask

   task automatic test_back_to_back();
      m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_adr_i = 3'd0;
      tick();
      checks++; if (gnt_o !== 2'b10) begin fails++; $display("FAIL b2b_gnt: gnt_o=%b expected 10", gnt_o); end
      m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 3'd3;
      s_dat_i = 8'h3C; s_ack_i = 1'b1;
      #1;
      checks++; if (m1_ack_o !== 1'b1 || m1_dat_o !== 8'h3C || m0_ack_o !== 1'b0 || s_adr_o !== 3'd0)
         begin fails++; $display("FAIL b2b_rd0: m1_ack=%b m1_dat=%h m0_ack=%b adr=%0d expected 1 3c 0 0", m1_ack_o, m1_dat_o, m0_ack_o, s_adr_o); end
      tick();
      m1_adr_i = 3'd1; s_dat_i = 8'hF0;
      #1;
      checks++; if (gnt_o !== 2'b10 || s_adr_o !== 3'd1 || m1_dat_o !== 8'hF0 || m0_dat_o !== 8'hF0 || m0_ack_o !== 1'b0)
         begin fails++; $display("FAIL b2b_rd1: gnt=%b adr=%0d m1_dat=%h m0_dat=%h m0_ack=%b expected 10 1 f0 f0 0", gnt_o, s_adr_o, m1_dat_o, m0_dat_o, m0_ack_o); end
      tick();
      m1_cyc_i = 1'b0; m1_stb_i = 1'b0; s_ack_i = 1'b0;
      #1;
      checks++; if (gnt_o !== 2'b10 || s_cyc_o !== 1'b0) begin fails++; $display("FAIL b2b_drop: gnt=%b cyc=%b expected 10 0", gnt_o, s_cyc_o); end
      tick();
      checks++; if (gnt_o !== 2'b01 || s_adr_o !== 3'd3) begin fails++; $display("FAIL b2b_next: gnt=%b adr=%0d expected 01 3", gnt_o, s_adr_o); end
      idle_inputs();
      tick();
   endtask

   task automatic test_late_request();
      m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
      tick();
      checks++; if (gnt_o !== 2'b01) begin fails++; $display("FAIL late_gnt: gnt_o=%b expected 01", gnt_o); end
      m1_cyc_i = 1'b1; m1_stb_i = 1'b1; s_ack_i = 1'b1;
      #1;
      checks++; if (m0_ack_o !== 1'b1 || m1_ack_o !== 1'b0) begin fails++; $display("FAIL late_ack: m0=%b m1=%b expected 1 0", m0_ack_o, m1_ack_o); end
      s_ack_i = 1'b0; s_err_i = 1'b1;
      #1;
      checks++; if (m0_err_o !== 1'b1 || m1_err_o !== 1'b0) begin fails++; $display("FAIL late_err: m0=%b m1=%b expected 1 0", m0_err_o, m1_err_o); end
      s_err_i = 1'b0; s_rty_i = 1'b1;
      #1;
      checks++; if (m0_rty_o !== 1'b1 || m1_rty_o !== 1'b0) begin fails++; $display("FAIL late_rty: m0=%b m1=%b expected 1 0", m0_rty_o, m1_rty_o); end
      s_rty_i = 1'b0;
      m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
      tick();
      checks++; if (gnt_o !== 2'b10) begin fails++; $display("FAIL late_handoff: gnt_o=%b expected 10", gnt_o); end
      idle_inputs();
      tick();
   endtask

   task automatic test_reset_mid();
      m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
      tick();
      checks++; if (gnt_o !== 2'b10 || s_stb_o !== 1'b1) begin fails++; $display("FAIL rstmid_pre: gnt=%b stb=%b expected 10 1", gnt_o, s_stb_o); end
      #2;
      wb_rst_n = 1'b0;
      #1;
      checks++; if (s_cyc_o !== 1'b0 || s_stb_o !== 1'b0 || gnt_o !== 2'b00 || m1_ack_o !== 1'b0)
         begin fails++; $display("FAIL rstmid_async: cyc=%b stb=%b gnt=%b ack=%b expected 0 0 00 0", s_cyc_o, s_stb_o, gnt_o, m1_ack_o); end
      #1;
      wb_rst_n = 1'b1;
      m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
      tick();
      checks++; if (gnt_o !== 2'b01) begin fails++; $display("FAIL rstmid_tie: gnt_o=%b expected 01", gnt_o); end
      idle_inputs();
      tick();
      tick();
   endtask

`ifdef GPIO_ARB_TIMEOUT_EN
   task automatic test_timeout();
      do_reset();
      m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
      tick();
      checks++; if (gnt_o !== 2'b01) begin fails++; $display("FAIL to_gnt: gnt_o=%b expected 01", gnt_o); end
      m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
      for (int k = 1; k < 16; k++) begin
         tick();
         checks++; if (m0_err_o !== 1'b0 || s_stb_o !== 1'b1) begin fails++; $display("FAIL to_wait%0d: err=%b stb=%b expected 0 1", k, m0_err_o, s_stb_o); end
      end
      tick();
      checks++; if (m0_err_o !== 1'b1 || s_stb_o !== 1'b0 || s_cyc_o !== 1'b0 || m1_err_o !== 1'b0)
         begin fails++; $display("FAIL to_expire: err=%b stb=%b cyc=%b m1_err=%b expected 1 0 0 0", m0_err_o, s_stb_o, s_cyc_o, m1_err_o); end
      tick();
      checks++; if (gnt_o !== 2'b00 || m0_err_o !== 1'b0) begin fails++; $display("FAIL to_idle: gnt=%b err=%b expected 00 0", gnt_o, m0_err_o); end
      tick();
      checks++; if (gnt_o !== 2'b10) begin fails++; $display("FAIL to_m1_next: gnt_o=%b expected 10", gnt_o); end
      idle_inputs();
      tick();
   endtask
`endif

   initial begin
      idle_inputs();
      wb_rst_n = 1'b0;
      test_reset();
      test_m0_write();
      test_tie();
      test_back_to_back();
      test_late_request();
      test_reset_mid();
`ifdef GPIO_ARB_TIMEOUT_EN
      test_timeout();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
